// File: rtl/fir_tap_loader.sv
// Sample-window front end for the wavelet FIR bank: shifts accepted samples into a
// NUM_ELEM-deep window, strobes the FIR at the decimation rate, and drains the window with zeros.
module fir_tap_loader #(
   parameter int BITS_PER_ELEM = 8,
   parameter int NUM_ELEM      = 7,
   parameter int DECIMATION    = 1
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic [BITS_PER_ELEM-1:0]          i_sample,
   input  logic                              i_sample_valid,
   output logic                              o_sample_ready,
   input  logic                              i_flush,
   output logic [NUM_ELEM*BITS_PER_ELEM-1:0] o_taps,
   output logic                              o_start_calc,
   output logic                              o_window_full,
   output logic [1:0]                        dbg_state
);

   localparam int TW = NUM_ELEM * BITS_PER_ELEM;
   localparam int CW = $clog2(NUM_ELEM + 1);
   localparam int DW = $clog2(DECIMATION + 1);
   localparam logic [CW-1:0] FILL_LAST = CW'(NUM_ELEM - 1);
   localparam logic [CW-1:0] FILL_MAX  = CW'(NUM_ELEM);
   localparam logic [DW-1:0] DEC_LAST  = DW'(DECIMATION - 1);

   typedef enum logic [1:0] {
      FILL   = 2'd0,
      STREAM = 2'd1,
      FLUSH  = 2'd2
   } state_t;

   state_t          state;
   logic [CW-1:0]   fill_cnt;
   logic [CW-1:0]   flush_cnt;
   logic [DW-1:0]   dec_cnt;
   logic            accept;

   // Handshake: a sample transfers on any cycle where i_sample_valid and o_sample_ready are
   // both high; ready is combinational and drops during a flush request, the drain, and reset.
   assign o_sample_ready = (state != FLUSH) && !i_flush && !reset;
   assign accept         = i_sample_valid && o_sample_ready;
   assign dbg_state      = state;

   always_ff @(posedge clk) begin
      if (reset) begin
         o_taps        <= '0;
         o_start_calc  <= 1'b0;
         o_window_full <= 1'b0;
         fill_cnt      <= '0;
         flush_cnt     <= '0;
         dec_cnt       <= '0;
         state         <= FILL;
      end else begin
         o_start_calc <= 1'b0;
         case (state)
            FILL: begin
               if (i_flush) begin
                  o_taps   <= '0;
                  fill_cnt <= '0;
               end else if (accept) begin
                  o_taps <= {o_taps[TW-BITS_PER_ELEM-1:0], i_sample};
                  if (fill_cnt == FILL_LAST) begin
                     fill_cnt      <= FILL_MAX;
                     o_start_calc  <= 1'b1;
                     dec_cnt       <= '0;
                     o_window_full <= 1'b1;
                     state         <= STREAM;
                  end else begin
                     fill_cnt <= fill_cnt + 1'b1;
                  end
               end
            end
            STREAM: begin
               if (i_flush) begin
                  flush_cnt <= '0;
                  state     <= FLUSH;
               end else if (accept) begin
                  o_taps <= {o_taps[TW-BITS_PER_ELEM-1:0], i_sample};
                  if (dec_cnt == DEC_LAST) begin
                     o_start_calc <= 1'b1;
                     dec_cnt      <= '0;
                  end else begin
                     dec_cnt <= dec_cnt + 1'b1;
                  end
               end
            end
            FLUSH: begin
               // Each zero shifted in gets its own strobe so the FIR output decays to zero.
               o_taps       <= {o_taps[TW-BITS_PER_ELEM-1:0], {BITS_PER_ELEM{1'b0}}};
               o_start_calc <= 1'b1;
               if (flush_cnt == FILL_LAST) begin
                  flush_cnt     <= '0;
                  fill_cnt      <= '0;
                  dec_cnt       <= '0;
                  o_window_full <= 1'b0;
                  state         <= FILL;
               end else begin
                  flush_cnt <= flush_cnt + 1'b1;
               end
            end
            default: state <= FILL;
         endcase
      end
   end

endmodule

// File: tb/tb_fir_tap_loader.sv
// Directed bench for fir_tap_loader: each expected strobe (cycle + window) is queued at drive
// time and a negedge monitor pops and compares whenever o_start_calc is high.
module tb_fir_tap_loader;

   localparam int B  = 8;
   localparam int N  = 7;
   localparam int TW = N * B;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [B-1:0]  i_sample = '0;
   logic          i_sample_valid = 1'b0;
   logic          i_flush = 1'b0;
   logic          o_sample_ready;
   logic [TW-1:0] o_taps;
   logic          o_start_calc;
   logic          o_window_full;
   logic [1:0]    dbg_state;

   logic [B-1:0]  s3 = '0;
   logic          v3 = 1'b0;
   logic          rdy3;
   logic [TW-1:0] taps3;
   logic          st3;
   logic          full3;
   logic [1:0]    dbg3;

   int cyc = 0;
   int n_cmp = 0;
   int n_bad = 0;

   logic [TW-1:0] exp_q[$];
   int            exp_cyc_q[$];
   logic [TW-1:0] exp3_q[$];
   int            exp3_cyc_q[$];

   fir_tap_loader #(.BITS_PER_ELEM(B), .NUM_ELEM(N), .DECIMATION(1)) dut (
      .clk(clk), .reset(reset), .i_sample(i_sample), .i_sample_valid(i_sample_valid),
      .o_sample_ready(o_sample_ready), .i_flush(i_flush), .o_taps(o_taps),
      .o_start_calc(o_start_calc), .o_window_full(o_window_full), .dbg_state(dbg_state)
   );

   fir_tap_loader #(.BITS_PER_ELEM(B), .NUM_ELEM(N), .DECIMATION(3)) dut3 (
      .clk(clk), .reset(reset), .i_sample(s3), .i_sample_valid(v3),
      .o_sample_ready(rdy3), .i_flush(1'b0), .o_taps(taps3),
      .o_start_calc(st3), .o_window_full(full3), .dbg_state(dbg3)
   );

   // clock / reset
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // driver: one clock of stimulus for the DECIMATION=1 instance
   task automatic send(input logic v, input logic [B-1:0] s, input logic f,
                       input logic exp_ready, input logic exp_strobe, input logic [TW-1:0] exp_taps);
      i_sample_valid = v;
      i_sample       = s;
      i_flush        = f;
      if (exp_strobe) begin
         exp_q.push_back(exp_taps);
         exp_cyc_q.push_back(cyc + 1);
      end
      #1;
      check("ready", {63'd0, o_sample_ready}, {63'd0, exp_ready});
      @(posedge clk);
      #1;
   endtask

   // driver: one accepted sample for the DECIMATION=3 instance
   task automatic send3(input logic [B-1:0] s, input logic exp_strobe, input logic [TW-1:0] exp_taps);
      v3 = 1'b1;
      s3 = s;
      if (exp_strobe) begin
         exp3_q.push_back(exp_taps);
         exp3_cyc_q.push_back(cyc + 1);
      end
      @(posedge clk);
      #1;
      v3 = 1'b0;
   endtask

   // scoreboard monitors
   always @(negedge clk) begin
      if (exp_cyc_q.size() > 0 && exp_cyc_q[0] < cyc) begin
         n_cmp++;
         n_bad++;
         $display("FAIL strobe_missing: got none expected strobe at cycle %0d", exp_cyc_q[0]);
         void'(exp_cyc_q.pop_front());
         void'(exp_q.pop_front());
      end
      if (o_start_calc) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL strobe_unexpected: got strobe at cycle %0d expected none, taps %0h", cyc, o_taps);
         end else begin
            if (exp_cyc_q[0] != cyc || o_taps !== exp_q[0]) begin
               n_bad++;
               $display("FAIL strobe_window: got cycle %0d taps %0h expected cycle %0d taps %0h",
                        cyc, o_taps, exp_cyc_q[0], exp_q[0]);
            end
            void'(exp_cyc_q.pop_front());
            void'(exp_q.pop_front());
         end
      end
   end

   always @(negedge clk) begin
      if (exp3_cyc_q.size() > 0 && exp3_cyc_q[0] < cyc) begin
         n_cmp++;
         n_bad++;
         $display("FAIL dec3_strobe_missing: got none expected strobe at cycle %0d", exp3_cyc_q[0]);
         void'(exp3_cyc_q.pop_front());
         void'(exp3_q.pop_front());
      end
      if (st3) begin
         n_cmp++;
         if (exp3_q.size() == 0) begin
            n_bad++;
            $display("FAIL dec3_strobe_unexpected: got strobe at cycle %0d expected none, taps %0h", cyc, taps3);
         end else begin
            if (exp3_cyc_q[0] != cyc || taps3 !== exp3_q[0]) begin
               n_bad++;
               $display("FAIL dec3_strobe_window: got cycle %0d taps %0h expected cycle %0d taps %0h",
                        cyc, taps3, exp3_cyc_q[0], exp3_q[0]);
            end
            void'(exp3_cyc_q.pop_front());
            void'(exp3_q.pop_front());
         end
      end
   end

   logic [TW-1:0] w;

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check("rst_taps", {8'd0, o_taps}, 64'd0);
      check("rst_start", {63'd0, o_start_calc}, 64'd0);
      check("rst_full", {63'd0, o_window_full}, 64'd0);
      check("rst_ready", {63'd0, o_sample_ready}, 64'd0);
      check("rst_state", {62'd0, dbg_state}, 64'd0);
      check("rst_taps3", {8'd0, taps3}, 64'd0);
      reset = 1'b0;
      #1;
      check("ready_after_rst", {63'd0, o_sample_ready}, 64'd1);

      // DECIMATION=3: strobes after accepts 7, 10, 13 only
      for (int k = 1; k <= 13; k++) begin
         case (k)
            7:       send3(B'(k), 1'b1, {8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7});
            10:      send3(B'(k), 1'b1, {8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9, 8'd10});
            13:      send3(B'(k), 1'b1, {8'd7, 8'd8, 8'd9, 8'd10, 8'd11, 8'd12, 8'd13});
            default: send3(B'(k), 1'b0, '0);
         endcase
      end
      check("dec3_full", {63'd0, full3}, 64'd1);

      // fill 1..7 back to back
      for (int k = 1; k <= 7; k++) begin
         send(1'b1, B'(k), 1'b0, 1'b1, k == 7, {8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7});
         if (k == 6) check("full_before", {63'd0, o_window_full}, 64'd0);
      end
      check("full_after", {63'd0, o_window_full}, 64'd1);
      check("state_stream", {62'd0, dbg_state}, 64'd1);

      // toggled valid, DECIMATION=1
      send(1'b1, 8'd8, 1'b0, 1'b1, 1'b1, {8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8});
      send(1'b0, 8'hEE, 1'b0, 1'b1, 1'b0, '0);
      send(1'b1, 8'd9, 1'b0, 1'b1, 1'b1, {8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9});
      send(1'b0, 8'hEE, 1'b0, 1'b1, 1'b0, '0);
      check("window_3_to_9", {8'd0, o_taps}, {8'd0, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9});

      // flush from STREAM with valid held high
      w = {8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
      send(1'b1, 8'hAA, 1'b1, 1'b0, 1'b0, '0);
      for (int j = 1; j <= N; j++) begin
         w = w << B;
         send(1'b1, 8'h55, 1'b0, 1'b0, 1'b1, w);
      end
      check("flush_taps", {8'd0, o_taps}, 64'd0);
      check("flush_full", {63'd0, o_window_full}, 64'd0);
      check("flush_state", {62'd0, dbg_state}, 64'd0);
      send(1'b1, 8'h42, 1'b0, 1'b1, 1'b0, '0);
      check("post_flush_elem0", {8'd0, o_taps}, 64'h42);
      for (int k = 1; k <= 6; k++)
         send(1'b1, B'(k), 1'b0, 1'b1, k == 6, {8'h42, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6});

      reset = 1'b1;
      send(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, '0);
      reset = 1'b0;

      // sign bits, then flush while in FILL
      send(1'b1, 8'h80, 1'b0, 1'b1, 1'b0, '0);
      send(1'b1, 8'h7F, 1'b0, 1'b1, 1'b0, '0);
      send(1'b1, 8'h01, 1'b0, 1'b1, 1'b0, '0);
      check("signed_window", {8'd0, o_taps}, 64'h807F01);
      send(1'b1, 8'h33, 1'b1, 1'b0, 1'b0, '0);
      check("fill_flush_taps", {8'd0, o_taps}, 64'd0);
      check("fill_flush_state", {62'd0, dbg_state}, 64'd0);
      send(1'b1, 8'h11, 1'b0, 1'b1, 1'b0, '0);
      for (int k = 10; k <= 15; k++)
         send(1'b1, B'(k), 1'b0, 1'b1, k == 15, {8'h11, 8'd10, 8'd11, 8'd12, 8'd13, 8'd14, 8'd15});

      // reset during the third FLUSH cycle
      w = {8'h11, 8'd10, 8'd11, 8'd12, 8'd13, 8'd14, 8'd15};
      send(1'b1, 8'hAA, 1'b1, 1'b0, 1'b0, '0);
      w = w << B;
      send(1'b1, 8'h55, 1'b0, 1'b0, 1'b1, w);
      w = w << B;
      send(1'b1, 8'h55, 1'b0, 1'b0, 1'b1, w);
      reset = 1'b1;
      send(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, '0);
      check("midflush_rst_taps", {8'd0, o_taps}, 64'd0);
      check("midflush_rst_start", {63'd0, o_start_calc}, 64'd0);
      check("midflush_rst_state", {62'd0, dbg_state}, 64'd0);
      check("midflush_rst_full", {63'd0, o_window_full}, 64'd0);
      reset = 1'b0;
      #1;
      check("midflush_ready", {63'd0, o_sample_ready}, 64'd1);

      repeat (3) @(posedge clk);
      #1;
      check("queue_empty", 64'(exp_q.size()), 64'd0);
      check("queue3_empty", 64'(exp3_q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
